// File: rtl/reaction_ctrl.sv
// Reaction-time game controller.
// Waits a pseudo-random delay after "start", lights the stimulus LED, then
// counts milliseconds in BCD until "react" is pressed. Early presses show 9999,
// and a run with no press saturates at 9999.
module reaction_ctrl #(
  parameter int TICK_DIV     = 100000,
  parameter int MIN_DELAY_MS = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic       active,
  output logic       mesg,
  output logic [3:0] hex3,
  output logic [3:0] hex2,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic [3:0] dp_in,
  output logic       led
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_TIME = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [12:0]   MIN_DELAY = 13'(MIN_DELAY_MS);
  localparam logic [15:0]   BCD_MAX   = 16'h9999;

  logic [1:0]    state, state_nx;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [12:0]   delay, delay_nx;
  logic [15:0]   lfsr;
  logic [15:0]   bcd, bcd_nx;
  logic          count_entry;

  // Four-digit BCD increment; each digit wraps 9->0 and carries upward.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign tick        = (tick_cnt == TICK_LAST);
  assign count_entry = (state_nx != state) && ((state_nx == ST_WAIT) || (state_nx == ST_TIME));

  // Next-state, delay and BCD decisions; clear > stop > start.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_nx = state;
    delay_nx = delay;
    bcd_nx   = bcd;
    if (clear) begin
      state_nx = ST_IDLE;
      bcd_nx   = 16'h0000;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state_nx = ST_WAIT;
          bcd_nx   = 16'h0000;
          delay_nx = MIN_DELAY + {1'b0, lfsr[11:0]};
        end
        ST_WAIT: if (stop) begin
          state_nx = ST_DONE;
          bcd_nx   = BCD_MAX;
        end else if (tick) begin
          // A delay of 0 or 1 both end on this tick, so the count never underflows.
          if (delay <= 13'd1) state_nx = ST_TIME;
          else                delay_nx = delay - 13'd1;
        end
        ST_TIME: if (stop) begin
          state_nx = ST_DONE;
        end else if (tick) begin
          if (bcd == BCD_MAX) state_nx = ST_DONE;
          else                bcd_nx   = bcd_inc(bcd);
        end
        default: ;
      endcase
    end
  end

  // Millisecond tick divider; restarts on entry to WAIT and TIME so phases align.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset || count_entry || tick) tick_cnt <= '0;
    else                              tick_cnt <= tick_cnt + 1'b1;
  end

  // Free-running LFSR, x^16+x^14+x^13+x^11+1; nonzero seed keeps it out of the lock-up state.
  always_ff @(posedge clk) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // State, delay and BCD registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      delay <= '0;
      bcd   <= '0;
    end else begin
      state <= state_nx;
      delay <= delay_nx;
      bcd   <= bcd_nx;
    end
  end

  // Display and LED outputs registered from the next state, so they change with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b1;
      mesg   <= 1'b1;
      led    <= 1'b0;
      dp_in  <= 4'b1111;
    end else begin
      active <= (state_nx != ST_WAIT);
      mesg   <= (state_nx == ST_IDLE);
      led    <= (state_nx == ST_TIME);
      dp_in  <= (state_nx == ST_IDLE) ? 4'b1111 : 4'b0111;
    end
  end

  assign hex3 = bcd[15:12];
  assign hex2 = bcd[11:8];
  assign hex1 = bcd[7:4];
  assign hex0 = bcd[3:0];

endmodule

// File: tb/tb_reaction_ctrl.sv
// Self-checking bench for reaction_ctrl with TICK_DIV=4, MIN_DELAY_MS=2.
// Expected outputs are queued as stimulus is driven and compared after the edge.
module tb_reaction_ctrl;

  localparam int TD = 4;
  localparam int MD = 2;

  logic       clk = 1'b0;
  logic       reset, start, stop, clear;
  logic       active, mesg, led;
  logic [3:0] hex3, hex2, hex1, hex0, dp_in;

  reaction_ctrl #(.TICK_DIV(TD), .MIN_DELAY_MS(MD)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .active(active), .mesg(mesg), .hex3(hex3), .hex2(hex2), .hex1(hex1),
    .hex0(hex0), .dp_in(dp_in), .led(led)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        active;
    logic        mesg;
    logic        led;
    logic [3:0]  dp;
    logic [15:0] hex;
  } obs_t;

  typedef struct {
    string name;
    obs_t  exp;
    obs_t  mask;
  } pend_t;

  typedef struct {
    int          n_ticks;
    int          phase;
    logic [15:0] exp_hex;
  } vec_t;

  pend_t q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  obs_t  cur;
  logic [15:0] m_lfsr;

  assign cur = {active, mesg, led, dp_in, hex3, hex2, hex1, hex0};

  // Reference LFSR used to predict the captured random delay.
  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic obs_t mask_all();
    return '1;
  endfunction

  function automatic obs_t mask_wait();
    obs_t m;
    m = '0;
    m.active = 1'b1;
    m.led    = 1'b1;
    m.hex    = '1;
    return m;
  endfunction

  function automatic obs_t o_idle();
    return {1'b1, 1'b1, 1'b0, 4'b1111, 16'h0000};
  endfunction

  function automatic obs_t o_wait();
    return {1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000};
  endfunction

  function automatic obs_t o_time(input logic [15:0] h);
    return {1'b1, 1'b0, 1'b1, 4'b0111, h};
  endfunction

  function automatic obs_t o_done(input logic [15:0] h);
    return {1'b1, 1'b0, 1'b0, 4'b0111, h};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp, input obs_t mask);
    obs_t a, e;
    a = act & mask;
    e = exp & mask;
    n_checks++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got active=%b mesg=%b led=%b dp=%b hex=%h, want active=%b mesg=%b led=%b dp=%b hex=%h",
                  name, a.active, a.mesg, a.led, a.dp, a.hex, e.active, e.mesg, e.led, e.dp, e.hex);
  endtask

  task automatic expect_out(input string name, input obs_t exp, input obs_t mask);
    pend_t p;
    p.name = name;
    p.exp  = exp;
    p.mask = mask;
    q.push_back(p);
  endtask

  // Advance one clock; then compare every expectation queued for this edge.
  task automatic step();
    pend_t p;
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      p = q.pop_front();
      check(p.name, cur, p.exp, p.mask);
    end
  endtask

  // Idle until the model LFSR gives a short delay, then pulse start.
  task automatic start_run(output int d);
    int found;
    found = 0;
    for (int i = 0; i < 20000; i++) begin
      if (m_lfsr[11:0] < 12'd24) begin
        found = 1;
        break;
      end
      expect_out("idle_hold", o_idle(), mask_all());
      step();
    end
    if (found == 0) begin
      n_checks++;
      $display("FAIL lfsr_search: no short delay found, got lfsr=%h want low bits < 24", m_lfsr);
    end
    d = MD + int'(m_lfsr[11:0]);
    start = 1'b1;
    expect_out("wait_entry", o_wait(), mask_wait());
    step();
    start = 1'b0;
  endtask

  // led must stay low for 4*d-1 cycles after WAIT entry and rise on cycle 4*d.
  task automatic run_to_led(input int d);
    for (int k = 1; k <= TD * d; k++) begin
      if (k < TD * d) expect_out("wait_led_low", o_wait(), mask_wait());
      else            expect_out("led_rise", o_time(16'h0000), mask_all());
      step();
    end
  endtask

  task automatic pulse_clear_to_idle(input string name);
    clear = 1'b1;
    expect_out(name, o_idle(), mask_all());
    step();
    clear = 1'b0;
  endtask

  vec_t vecs[8];
  int   d;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Stop sampled at the edge 4*n_ticks+phase cycles after led rose; phase 0 coincides with a tick.
    vecs[0] = '{37,   1, 16'h0037};
    vecs[1] = '{0,    1, 16'h0000};
    vecs[2] = '{1,    1, 16'h0001};
    vecs[3] = '{9,    3, 16'h0009};
    vecs[4] = '{10,   2, 16'h0010};
    vecs[5] = '{43,   0, 16'h0042};
    vecs[6] = '{100,  0, 16'h0099};
    vecs[7] = '{1000, 1, 16'h1000};

    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
    repeat (3) begin
      expect_out("reset_state", o_idle(), mask_all());
      step();
    end
    reset = 1'b0;
    repeat (10) begin
      expect_out("idle_after_reset", o_idle(), mask_all());
      step();
    end

    // Table of measured reaction times.
    for (int i = 0; i < 8; i++) begin
      start_run(d);
      run_to_led(d);
      repeat (TD * vecs[i].n_ticks + vecs[i].phase - 1) step();
      stop = 1'b1;
      expect_out("stop_freeze", o_done(vecs[i].exp_hex), mask_all());
      step();
      stop = 1'b0;
      repeat (3) begin
        expect_out("done_hold", o_done(vecs[i].exp_hex), mask_all());
        step();
      end
      pulse_clear_to_idle("clear_idle");
    end

    // Early press during WAIT, then start ignored in DONE.
    start_run(d);
    repeat (3) begin
      expect_out("early_wait", o_wait(), mask_wait());
      step();
    end
    stop = 1'b1;
    expect_out("early_stop", o_done(16'h9999), mask_all());
    step();
    stop = 1'b0;
    start = 1'b1;
    expect_out("start_in_done", o_done(16'h9999), mask_all());
    step();
    start = 1'b0;
    repeat (TD * 3) begin
      expect_out("early_done_hold", o_done(16'h9999), mask_all());
      step();
    end
    pulse_clear_to_idle("early_clear");

    // clear and stop together while timing: clear wins.
    start_run(d);
    run_to_led(d);
    repeat (20) step();
    clear = 1'b1;
    stop  = 1'b1;
    expect_out("clear_beats_stop", o_idle(), mask_all());
    step();
    clear = 1'b0;
    stop  = 1'b0;
    expect_out("idle_after_clear", o_idle(), mask_all());
    step();

    // reset in the middle of TIME.
    start_run(d);
    run_to_led(d);
    repeat (10) step();
    reset = 1'b1;
    expect_out("reset_mid_time", o_idle(), mask_all());
    step();
    reset = 1'b0;
    expect_out("no_residual_led", o_idle(), mask_all());
    step();

    // No press: saturate at 9999 and finish on the 10000th tick.
    start_run(d);
    run_to_led(d);
    repeat (TD * 9999 - 1) step();
    expect_out("reach_9999", o_time(16'h9999), mask_all());
    step();
    repeat (TD - 1) begin
      expect_out("hold_9999", o_time(16'h9999), mask_all());
      step();
    end
    expect_out("timeout_done", o_done(16'h9999), mask_all());
    step();
    expect_out("timeout_hold", o_done(16'h9999), mask_all());
    step();
    pulse_clear_to_idle("timeout_clear");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reaction_ctrl.md
REACTION_CTRL -- requirements
Module: reaction_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100000, clock cycles per 1 ms tick (100 MHz clock).
REQ-002 Parameter MIN_DELAY_MS, default 2000, minimum random wait in ms.
REQ-003 clk  input  1  system clock; single clock domain, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse from the debounced "start" button.
REQ-006 stop  input  1  one-cycle pulse from the debounced "react" button.
REQ-007 clear  input  1  one-cycle pulse from the debounced "clear" button.
REQ-008 active  output  1  display enable to the hex display mux; 0 blanks all digits.
REQ-009 mesg  output  1  1 selects the "HI" message; 0 selects hex digits.
REQ-010 hex3, hex2, hex1, hex0  output  4 each  BCD digits, thousands of ms (hex3) to ms (hex0).
REQ-011 dp_in  output  4  active-low decimal points; bit3 maps to digit 3.
REQ-012 led  output  1  stimulus LED, 1 = lit.

Function
REQ-013 FSM states: IDLE, WAIT, TIME and DONE; all outputs are registered.
REQ-014 Tick generator: a 0..TICK_DIV-1 counter; tick asserts for one cycle at TICK_DIV-1; the counter clears to 0 on entry to WAIT and to TIME.
REQ-015 LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, shifting every cycle including in IDLE, seed 16'hACE1, never all-zero.
REQ-016 IDLE: active=1, mesg=1 ("HI"), led=0; on start, capture delay = MIN_DELAY_MS + lfsr[11:0] (range 2000..6095 ms at default), clear BCD to 0000, and go to WAIT next cycle.
REQ-017 WAIT: active=0, led=0; decrement the delay counter on each tick; on the tick where it equals 1, go to TIME, so led rises exactly delay×TICK_DIV cycles after WAIT entry.
REQ-018 WAIT + stop (early press): go to DONE with BCD forced to 9999.
REQ-019 TIME: led=1, active=1, mesg=0; on each tick increment the 4-digit BCD counter, with each digit wrapping 9->0 and carrying to the next digit.
REQ-020 TIME + stop: go to DONE next cycle with BCD frozen at its current value; if a tick coincides with stop, that tick's increment is not applied.
REQ-021 TIME: a tick while BCD = 9999 does not wrap; BCD holds 9999 and the FSM goes to DONE (timeout).
REQ-022 DONE: led=0, active=1, mesg=0, digits hold; only clear leaves DONE.
REQ-023 clear in any state: go to IDLE next cycle, with led=0 and BCD cleared to 0000.
REQ-024 Priority for simultaneous inputs is clear > stop > start; start outside IDLE is ignored; stop in IDLE or DONE is ignored.
REQ-025 dp_in = 4'b0111 (digit-3 point lit, shows s.mmm) whenever mesg=0; otherwise dp_in = 4'b1111.
REQ-026 Width rules: the delay counter is 13 bits; the tick counter is ceil(log2(TICK_DIV)) bits; no arithmetic overflow is permitted.

Reset
REQ-027 While reset=1 at a clock edge, the next state is: IDLE, active=1, mesg=1, hex3..hex0=0, dp_in=4'b1111, led=0, LFSR=16'hACE1, tick and delay counters 0.
REQ-028 reset mid-operation (WAIT or TIME) abandons the measurement with no residual led pulse on the following cycle.

Verification (TICK_DIV=4, MIN_DELAY_MS=2)
REQ-029 Reset then idle 10 cycles -> active=1, mesg=1, led=0, dp_in=1111 throughout.
REQ-030 start at a known cycle (model LFSR) giving delay D -> led rises exactly 4·D cycles after WAIT entry; stop 4·37 cycles later -> DONE with hex=0,0,3,7, led=0, dp_in=0111.
REQ-031 stop during WAIT -> DONE with hex=9,9,9,9, led never asserted.
REQ-032 No stop after led rises -> after 9999 ticks, hex=9999 and the FSM enters DONE on the 10000th tick, with no wrap to 0000.
REQ-033 stop coinciding with a tick in TIME at BCD 0042 -> display holds 0042; clear+stop in the same cycle -> IDLE with BCD 0000.
REQ-034 reset asserted mid-TIME -> next cycle matches REQ-027 values; start in DONE is ignored until clear.
